// File: rtl/d_drain_serializer_pkg.sv
// Shared types and constants for the D0/D1 drain serializer.
package d_drain_serializer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StCapture,
        StShift
    } state_e;

    localparam int unsigned FrameBits = 8;
    localparam logic        StartBit  = 1'b1;
    localparam logic        ChD0      = 1'b0;
    localparam logic        ChD1      = 1'b1;

    // Round-robin pick; only meaningful when at least one FIFO is non-empty.
    function automatic logic arb_pick(input logic empty_d0, input logic empty_d1,
                                      input logic last_served);
        if (!empty_d0 && !empty_d1) begin
            return ~last_served;
        end
        return empty_d0 ? ChD1 : ChD0;
    endfunction

endpackage

// File: rtl/piso_shift8.sv
// 8-bit parallel-load, serial-out shift register, LSB first, zero fill.
module piso_shift8 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    output logic       serial_o
);

    logic [7:0] shift_q;

    // Load has priority; zero fill leaves the output low once a frame drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else if (load_i) begin
            shift_q <= data_i;
        end else if (shift_i) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end
    end

    assign serial_o = shift_q[0];

endmodule

// File: rtl/d_drain_serializer.sv
// Drains the D0/D1 FIFOs round-robin and emits each word as an 8-bit serial frame
// {data[5:0], channel, start}, LSB first, with per-channel sent-word counters.
module d_drain_serializer
    import d_drain_serializer_pkg::*;
#(
    parameter int unsigned DataWidth = 6,
    parameter int unsigned CntWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 empty_fifo_d0_i,
    input  logic                 empty_fifo_d1_i,
    input  logic [DataWidth-1:0] data_out_d0_i,
    input  logic [DataWidth-1:0] data_out_d1_i,
    output logic                 d0_pop_o,
    output logic                 d1_pop_o,
    output logic                 serial_out_o,
    output logic                 serial_valid_o,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  sent_d0_o,
    output logic [CntWidth-1:0]  sent_d1_o
);

    localparam int unsigned             BitCntWidth = $clog2(FrameBits);
    localparam logic [BitCntWidth-1:0] LastBit     = BitCntWidth'(FrameBits - 1);

    state_e                 state_q;
    logic                   chan_q;
    logic                   last_q;
    logic                   valid_q;
    logic [BitCntWidth-1:0] bit_cnt_q;
    logic [CntWidth-1:0]    sent_d0_q;
    logic [CntWidth-1:0]    sent_d1_q;

    logic                   work_pending;
    logic                   pick;
    logic [DataWidth-1:0]   cap_data;
    logic [FrameBits-1:0]   frame;
    logic                   load;
    logic                   shift;

    // Decision inputs and frame assembly from the selected FIFO's read data.
    always_comb begin
        work_pending = enable_i && !(empty_fifo_d0_i && empty_fifo_d1_i);
        pick         = arb_pick(empty_fifo_d0_i, empty_fifo_d1_i, last_q);
        cap_data     = (chan_q == ChD1) ? data_out_d1_i : data_out_d0_i;
        frame        = {cap_data[FrameBits-3:0], chan_q, StartBit};
    end

    // Control FSM with arbiter state and sent-word counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            chan_q    <= ChD0;
            last_q    <= ChD1;
            valid_q   <= 1'b0;
            bit_cnt_q <= '0;
            sent_d0_q <= '0;
            sent_d1_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (work_pending) begin
                        state_q <= StPop;
                        chan_q  <= pick;
                        last_q  <= pick;
                    end
                end
                StPop: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    state_q   <= StShift;
                    bit_cnt_q <= '0;
                    valid_q   <= 1'b1;
                    if (chan_q == ChD1) begin
                        sent_d1_q <= sent_d1_q + CntWidth'(1);
                    end else begin
                        sent_d0_q <= sent_d0_q + CntWidth'(1);
                    end
                end
                StShift: begin
                    if (bit_cnt_q == LastBit) begin
                        // Last bit doubles as a decision cycle for back-to-back frames.
                        valid_q <= 1'b0;
                        if (work_pending) begin
                            state_q <= StPop;
                            chan_q  <= pick;
                            last_q  <= pick;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BitCntWidth'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Pop strobes and shifter controls decoded from the registered state.
    always_comb begin
        d0_pop_o = (state_q == StPop) && (chan_q == ChD0);
        d1_pop_o = (state_q == StPop) && (chan_q == ChD1);
        load     = (state_q == StCapture);
        shift    = (state_q == StShift);
    end

    piso_shift8 u_piso (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (load),
        .shift_i  (shift),
        .data_i   (frame),
        .serial_o (serial_out_o)
    );

    assign serial_valid_o = valid_q;
    assign busy_o         = (state_q != StIdle);
    assign sent_d0_o      = sent_d0_q;
    assign sent_d1_o      = sent_d1_q;

endmodule
